// File: rtl/bp_pkg.sv
// bp_pkg: shared types and the 2-bit saturating counter helper for the PHT update path
package bp_pkg;
  localparam int BP_N = 2;
  typedef enum logic {BP_INIT, BP_RUN} bp_ctrl_state_t;
  typedef struct packed {logic [BP_N-1:0] idx; logic taken;} pht_upd_t;
  function automatic logic [1:0] sat_cnt2(input logic [1:0] c, input logic taken);
    return taken ? (c == 2'd3 ? c : c + 2'd1) : (c == 2'd0 ? c : c - 2'd1);
  endfunction
endpackage

// File: rtl/bp_upd_fifo.sv
// bp_upd_fifo: synchronous FIFO of resolved-branch updates with clear and occupancy count
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  pht_upd_t                 din,
  output pht_upd_t                 dout,
  output logic [$clog2(DEPTH):0]   cnt
);
  localparam int AW = $clog2(DEPTH);
  pht_upd_t r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  // guards keep cnt inside 0..DEPTH even if the caller misbehaves
  assign w_pop  = pop && r_cnt != '0;
  assign w_push = push && (r_cnt != (AW+1)'(DEPTH) || w_pop);
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= w_push ? r_wp + AW'(1) : r_wp;
      r_rp  <= w_pop ? r_rp + AW'(1) : r_rp;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push && !(reset || clr)) r_mem[r_wp] <= din;
  end
  assign dout = r_mem[r_rp];
  assign cnt  = r_cnt;
endmodule

// File: rtl/pht_update_ctrl.sv
// pht_update_ctrl: sweeps the gshare PHT to a known value after reset/flush, then
// drains queued branch updates as one saturating read-modify-write per cycle.
module pht_update_ctrl
  import bp_pkg::*;
#(
  parameter int         N        = BP_N,
  parameter int         DEPTH    = 4,
  parameter logic [1:0] INIT_VAL = 2'b11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_req,
  input  logic         upd_valid,
  output logic         upd_ready,
  input  logic [N-1:0] upd_idx,
  input  logic         upd_taken,
  output logic [N-1:0] pht_raddr,
  input  logic [1:0]   pht_rdata,
  output logic         pht_we,
  output logic [N-1:0] pht_waddr,
  output logic [1:0]   pht_wdata,
  output logic         pred_enable,
  output logic         hist_clr
);
  localparam int CW = $clog2(DEPTH) + 1;
  bp_ctrl_state_t r_state, w_state_nx;
  logic [N-1:0] r_swp, w_swp_nx;
  logic [CW-1:0] w_cnt;
  pht_upd_t w_head, w_din;
  logic w_run, w_pop, w_push, w_clr;
  assign w_run     = !reset && r_state == BP_RUN;
  assign w_pop     = w_run && w_cnt != '0;
  assign upd_ready = w_run && !flush_req && (w_cnt != CW'(DEPTH) || w_pop);
  assign w_push    = upd_valid && upd_ready;
  // the queue stays empty for the whole sweep and is dropped on a flush
  assign w_clr     = !w_run || flush_req;
  assign w_din     = {upd_idx, upd_taken};
  bp_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_head),
    .cnt   (w_cnt)
  );
  always_comb begin
    w_state_nx = flush_req ? BP_INIT : r_state;
    w_swp_nx   = '0;
    pht_we     = w_pop;
    pht_waddr  = w_head.idx;
    pht_wdata  = sat_cnt2(pht_rdata, w_head.taken);
    if (r_state == BP_INIT) begin
      w_swp_nx   = flush_req ? '0 : r_swp + N'(1);
      w_state_nx = (!flush_req && r_swp == '1) ? BP_RUN : BP_INIT;
      pht_we     = !reset;
      pht_waddr  = r_swp;
      pht_wdata  = INIT_VAL;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= BP_INIT;
      r_swp   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_swp   <= w_swp_nx;
    end
  end
  assign pht_raddr   = w_head.idx;
  assign pred_enable = w_run;
  assign hist_clr    = !w_run;
endmodule

// File: tb/tb_pht_update_ctrl.sv
// tb_pht_update_ctrl: directed table/sequence checks plus a queue-based reference
// model that checks every cycle under random traffic, flushes and resets.
module tb_pht_update_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1, flush_req = 1'b0, upd_valid = 1'b0, upd_taken = 1'b0;
  logic [1:0] upd_idx = 2'd0;
  logic upd_ready, pht_we, pred_enable, hist_clr;
  logic [1:0] pht_raddr, pht_waddr, pht_wdata, pht_rdata;
  logic [1:0] ram [4] = '{default: 2'd0};
  int n_chk = 0, n_err = 0;

  pht_update_ctrl dut (
    .clk(clk), .reset(reset), .flush_req(flush_req), .upd_valid(upd_valid),
    .upd_ready(upd_ready), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .pht_raddr(pht_raddr), .pht_rdata(pht_rdata), .pht_we(pht_we),
    .pht_waddr(pht_waddr), .pht_wdata(pht_wdata), .pred_enable(pred_enable),
    .hist_clr(hist_clr)
  );

  always #5 clk = ~clk;
  assign pht_rdata = ram[pht_raddr];
  always @(posedge clk) if (pht_we) ram[pht_waddr] <= pht_wdata;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: mode flag, sweep position, update queue, PHT image
  typedef struct {int idx; bit taken;} upd_t;
  upd_t q[$];
  int mpht [4] = '{0, 0, 0, 0};
  bit m_init = 1'b1;
  int m_swp = 0;

  function automatic int sat(input int c, input bit t);
    return t ? (c == 3 ? 3 : c + 1) : (c == 0 ? 0 : c - 1);
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      chk("m_rst_we", pht_we, 0);
      chk("m_rst_ready", upd_ready, 0);
      chk("m_rst_pe", pred_enable, 0);
      chk("m_rst_hc", hist_clr, 1);
    end else if (m_init) begin
      chk("m_init_we", pht_we, 1);
      chk("m_init_waddr", pht_waddr, m_swp);
      chk("m_init_wdata", pht_wdata, 3);
      chk("m_init_ready", upd_ready, 0);
      chk("m_init_pe", pred_enable, 0);
      chk("m_init_hc", hist_clr, 1);
    end else begin
      chk("m_run_we", pht_we, q.size() > 0);
      chk("m_run_ready", upd_ready, !flush_req);
      chk("m_run_pe", pred_enable, 1);
      chk("m_run_hc", hist_clr, 0);
      if (q.size() > 0) begin
        chk("m_run_raddr", pht_raddr, q[0].idx);
        chk("m_run_waddr", pht_waddr, q[0].idx);
        chk("m_run_wdata", pht_wdata, sat(mpht[q[0].idx], q[0].taken));
      end
    end
  end

  always @(posedge clk) begin
    bit pop, rdy;
    if (reset) begin
      m_init = 1'b1;
      m_swp = 0;
      q.delete();
    end else if (m_init) begin
      mpht[m_swp] = 3;
      if (flush_req) m_swp = 0;
      else if (m_swp == 3) begin
        m_init = 1'b0;
        m_swp = 0;
      end else m_swp++;
    end else begin
      pop = q.size() > 0;
      rdy = !flush_req && (q.size() < 4 || pop);
      if (pop) begin
        mpht[q[0].idx] = sat(mpht[q[0].idx], q[0].taken);
        void'(q.pop_front());
      end
      if (flush_req) begin
        m_init = 1'b1;
        m_swp = 0;
        q.delete();
      end else if (upd_valid && rdy) q.push_back('{int'(upd_idx), upd_taken});
    end
  end

  task automatic drv(input bit r, input bit f, input bit v, input int i, input bit t);
    reset = r;
    flush_req = f;
    upd_valid = v;
    upd_idx = 2'(i);
    upd_taken = t;
    @(negedge clk);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_sweep(input string nm);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk({nm, "_we"}, pht_we, 1);
      chk({nm, "_waddr"}, pht_waddr, k);
      chk({nm, "_wdata"}, pht_wdata, 3);
      chk({nm, "_pe"}, pred_enable, 0);
      tick();
    end
    @(negedge clk);
    chk({nm, "_pe_rise"}, pred_enable, 1);
    chk({nm, "_hc_fall"}, hist_clr, 0);
    chk({nm, "_no_stale"}, pht_we, 0);
  endtask

  typedef struct {bit v; int idx; bit t; bit we; int wa; int wd;} vec_t;
  vec_t tbl [10];

  initial begin
    tbl[0] = '{1, 1, 0, 0, 0, 0};
    tbl[1] = '{1, 1, 0, 1, 1, 2};
    tbl[2] = '{0, 0, 0, 1, 1, 1};
    tbl[3] = '{1, 2, 1, 0, 0, 0};
    tbl[4] = '{1, 0, 0, 1, 2, 3};
    tbl[5] = '{1, 0, 0, 1, 0, 2};
    tbl[6] = '{1, 0, 0, 1, 0, 1};
    tbl[7] = '{1, 0, 0, 1, 0, 0};
    tbl[8] = '{0, 0, 0, 1, 0, 0};
    tbl[9] = '{0, 0, 0, 0, 0, 0};
    // reset cycle, then the 4-entry sweep, then RUN
    drv(1, 0, 0, 0, 0);
    chk("rst_we", pht_we, 0);
    chk("rst_pe", pred_enable, 0);
    chk("rst_hc", hist_clr, 1);
    chk("rst_ready", upd_ready, 0);
    tick();
    reset = 1'b0;
    chk_sweep("boot");
    tick();
    // updates, same-idx back-to-back and saturation at both ends
    foreach (tbl[n]) begin
      drv(0, 0, tbl[n].v, tbl[n].idx, tbl[n].t);
      chk($sformatf("tbl%0d_we", n), pht_we, tbl[n].we);
      chk($sformatf("tbl%0d_ready", n), upd_ready, 1);
      if (tbl[n].we) begin
        chk($sformatf("tbl%0d_waddr", n), pht_waddr, tbl[n].wa);
        chk($sformatf("tbl%0d_wdata", n), pht_wdata, tbl[n].wd);
      end
      tick();
    end
    // steady drain: a push is accepted every cycle
    for (int k = 0; k < 8; k++) begin
      drv(0, 0, 1, 3, 1);
      chk("drain_ready", upd_ready, 1);
      chk("drain_we", pht_we, k > 0);
      tick();
    end
    drv(0, 0, 0, 0, 0);
    chk("drain_last_we", pht_we, 1);
    tick();
    // flush with a queued update: head write happens, push refused, then resweep
    drv(0, 0, 1, 3, 1);
    chk("fl_pre_ready", upd_ready, 1);
    tick();
    drv(0, 1, 1, 1, 0);
    chk("fl_ready", upd_ready, 0);
    chk("fl_we", pht_we, 1);
    chk("fl_waddr", pht_waddr, 3);
    chk("fl_wdata", pht_wdata, 3);
    tick();
    flush_req = 1'b0;
    upd_valid = 1'b1;
    upd_idx = 2'd2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fl_sweep_ready", upd_ready, 0);
      tick();
      if (k == 3) upd_valid = 1'b0;
    end
    drv(0, 0, 0, 0, 0);
    chk("fl_no_stale_we", pht_we, 0);
    chk("fl_pe", pred_enable, 1);
    tick();
    // reset in mid-sweep at swp=2 restarts a full sweep
    drv(1, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    drv(1, 0, 0, 0, 0);
    chk("mid_rst_we", pht_we, 0);
    chk("mid_rst_hc", hist_clr, 1);
    tick();
    reset = 1'b0;
    chk_sweep("resweep");
    tick();
    // random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      drv($urandom_range(0, 249) == 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 2) != 0, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      tick();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
